fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
- Sequences the RV32I fetch stage: owns the program counter and the instruction-memory request handshake, and arbitrates redirect sources (jalr > jal > branch) against stall.
- Targets arrive as absolute addresses from EX; this block applies no offset compensation.
- Sits between the EX-stage redirect logic, the hazard unit (stall) and the instruction memory; drives the flush to IF/ID.

Parameters:
- XLEN, 32, address/PC width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- FLUSH_CYCLES, 2, cycles flush_o stays high after a redirect; legal range 1..7.
- CNT_W, 32, width of the performance counters (optional feature only).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- stall_i  in  1  hazard unit hold; PC frozen, no new request.
- jalr_i  in  1  jalr redirect.
- jal_i  in  1  jal redirect.
- br_i  in  1  taken-branch redirect.
- jalr_tgt_i  in  XLEN  jalr target (rs1+imm).
- jal_tgt_i  in  XLEN  jal absolute target.
- br_tgt_i  in  XLEN  branch absolute target.
- imem_ready_i  in  1  imem accepts request this cycle.
- imem_req_o  out  1  fetch request.
- imem_addr_o  out  XLEN  fetch address (equals pc_o).
- pc_o  out  XLEN  current fetch PC.
- fetch_valid_o  out  1  registered pulse: the fetch accepted last cycle is valid.
- fetch_pc_o  out  XLEN  address of that accepted fetch.
- flush_o  out  1  kill IF/ID contents.
- misalign_o  out  1  sticky misaligned-target error.
- stall_cnt_o  out  CNT_W  stall-cycle count.
- redir_cnt_o  out  CNT_W  redirect count.

Behaviour:
- Reset (synchronous, active-high; wins over everything, including mid-flush):
  - pc_o = RESET_PC; state = BOOT; flush counter = 0.
  - fetch_valid_o, fetch_pc_o, flush_o, misalign_o, counters = 0.
- States: BOOT, RUN, FLUSH, HALT.
- BOOT: imem_req_o = 0; unconditionally moves to RUN next cycle.
- Request logic (combinational): imem_req_o = (state is RUN or FLUSH) && !stall_i && !redirect, where redirect = jalr_i | jal_i | br_i. imem_addr_o = pc_o.
- Accept = imem_req_o && imem_ready_i:
  - pc_o <= pc_o + 4, wrapping modulo 2^XLEN.
  - Next cycle: fetch_valid_o = 1, fetch_pc_o = accepted address.
  - fetch_valid_o is 0 in every cycle that does not follow an accept.
- Per-cycle priority in RUN/FLUSH: redirect > stall > accept > hold (not ready: PC and address held, request remains asserted).
- Redirect target selection:
  - jalr: jalr_tgt_i with bit 0 cleared.
  - else jal: jal_tgt_i.
  - else branch: br_tgt_i.
- Redirect, target[1:0] == 0:
  - pc_o <= target; state -> FLUSH; counter <= FLUSH_CYCLES-1.
  - flush_o = 1 next cycle.
- Redirect, target[1:0] != 0:
  - state -> HALT; misalign_o <= 1; pc_o holds.
- FLUSH:
  - flush_o = 1 while in state, so FLUSH_CYCLES consecutive cycles.
  - Fetching of the target proceeds normally.
  - Counter decrements every cycle, stalled or not.
  - Counter == 0: return to RUN.
  - Redirect in FLUSH re-targets and reloads the counter.
- HALT: imem_req_o = 0; flush_o = 0; all inputs ignored until reset.
- Stall with redirect in the same cycle: redirect wins.
- Stall in RUN: pc_o held, no accept.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - stall_cnt_o increments each cycle stall_i=1 in RUN/FLUSH.
  - redir_cnt_o increments on each accepted redirect, including misaligned ones.
  - Both wrap at 2^CNT_W and clear on reset.
- Undefined: both ports tied to 0; no counter flops.

Decomposition:
- Shared package rv32_pkg:
  - fetch_state_e enum (BOOT, RUN, FLUSH, HALT).
  - INSTR_BYTES = 4.
  - redir_src_e enum (NONE, JALR, JAL, BR) used by the target mux.
- One natural sub-module, redirect_sel: combinational priority mux producing redirect, target and misaligned flag.

Test Plan:
1. Reset with ready=1, no events → BOOT 1 cycle, then imem_addr 0x0, 0x4, 0x8 on consecutive cycles; fetch_valid_o first high on cycle 3 after reset release with fetch_pc_o=0x0.
2. imem_ready_i=0 for 3 cycles at pc 0x10 → imem_req_o held high, imem_addr_o=0x10 throughout; no fetch_valid_o; advances to 0x14 after ready.
3. jalr_i=1 (jalr_tgt=0x101), jal_i=1 (jal_tgt=0x200), br_i=1 in the same cycle → pc_o=0x100 next cycle; flush_o high exactly 2 cycles; redir_cnt_o=1 with macro defined.
4. stall_i high 4 cycles at pc 0x20 → imem_req_o=0, pc_o=0x20 held; stall_cnt_o=4; resumes at 0x20.
5. br_i with br_tgt=0x42 → misalign_o=1, imem_req_o=0 thereafter; reset clears misalign_o and returns pc_o to RESET_PC.
6. Redirect to 0x80; second redirect to 0xC0 on the 2nd flush cycle; reset asserted mid-FLUSH → pc_o=0xC0 with flush re-extended 2 cycles; reset forces pc=0, flush_o=0 next cycle.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared fetch-stage types: controller states, redirect sources and instruction size.
package rv32_pkg;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        FLUSH,
        HALT
    } fetch_state_e;

    typedef enum logic [1:0] {
        NONE,
        JALR,
        JAL,
        BR
    } redir_src_e;

    localparam int INSTR_BYTES = 4;

endpackage : rv32_pkg

// File: rtl/redirect_sel.sv
// Priority mux over the EX-stage redirect sources (jalr > jal > branch).
// Produces the winning target and flags it when it is not word aligned.
module redirect_sel
    import rv32_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            jalr_i,
    input  logic            jal_i,
    input  logic            br_i,
    input  logic [XLEN-1:0] jalr_tgt_i,
    input  logic [XLEN-1:0] jal_tgt_i,
    input  logic [XLEN-1:0] br_tgt_i,
    output logic            redirect_o,
    output logic [XLEN-1:0] target_o,
    output logic            misaligned_o
);

    redir_src_e src;

    always_comb begin
        src = NONE;
        if (jalr_i) begin
            src = JALR;
        end else if (jal_i) begin
            src = JAL;
        end else if (br_i) begin
            src = BR;
        end
    end

    // jalr clears bit 0 of rs1+imm as the ISA requires; the other targets pass through.
    always_comb begin
        target_o = '0;
        case (src)
            JALR:    target_o = {jalr_tgt_i[XLEN-1:1], 1'b0};
            JAL:     target_o = jal_tgt_i;
            BR:      target_o = br_tgt_i;
            default: target_o = '0;
        endcase
    end

    assign redirect_o   = (src != NONE);
    assign misaligned_o = redirect_o && (target_o[1:0] != 2'b00);

endmodule : redirect_sel

// File: rtl/fetch_ctrl.sv
// RV32I fetch sequencer: PC, imem handshake, redirect arbitration and IF/ID flush.
// Define FETCH_PERF_CNT_EN to build the stall/redirect performance counters.
module fetch_ctrl
    import rv32_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_PC     = 32'h0000_0000,
    parameter int              FLUSH_CYCLES = 2,
    parameter int              CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_i,
    input  logic             jalr_i,
    input  logic             jal_i,
    input  logic             br_i,
    input  logic [XLEN-1:0]  jalr_tgt_i,
    input  logic [XLEN-1:0]  jal_tgt_i,
    input  logic [XLEN-1:0]  br_tgt_i,
    input  logic             imem_ready_i,
    output logic             imem_req_o,
    output logic [XLEN-1:0]  imem_addr_o,
    output logic [XLEN-1:0]  pc_o,
    output logic             fetch_valid_o,
    output logic [XLEN-1:0]  fetch_pc_o,
    output logic             flush_o,
    output logic             misalign_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] redir_cnt_o
);

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [2:0]      flush_cnt_q, flush_cnt_d;
    logic            fetch_valid_q, fetch_valid_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic            misalign_q, misalign_d;

    logic            redirect;
    logic [XLEN-1:0] target;
    logic            misaligned;
    logic            active;
    logic            accept;

    redirect_sel #(
        .XLEN(XLEN)
    ) u_redirect_sel (
        .jalr_i       (jalr_i),
        .jal_i        (jal_i),
        .br_i         (br_i),
        .jalr_tgt_i   (jalr_tgt_i),
        .jal_tgt_i    (jal_tgt_i),
        .br_tgt_i     (br_tgt_i),
        .redirect_o   (redirect),
        .target_o     (target),
        .misaligned_o (misaligned)
    );

    assign active     = (state_q == RUN) || (state_q == FLUSH);
    assign imem_req_o = active && !stall_i && !redirect;
    assign accept     = imem_req_o && imem_ready_i;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            flush_cnt_q   <= '0;
            fetch_valid_q <= 1'b0;
            fetch_pc_q    <= '0;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            flush_cnt_q   <= flush_cnt_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_pc_q    <= fetch_pc_d;
            misalign_q    <= misalign_d;
        end
    end

    // Redirect overrides everything; otherwise the flush window keeps counting
    // down even while stalled, and fetching continues underneath it.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        flush_cnt_d   = flush_cnt_q;
        fetch_valid_d = 1'b0;
        fetch_pc_d    = fetch_pc_q;
        misalign_d    = misalign_q;
        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN, FLUSH: begin
                if (state_q == FLUSH) begin
                    if (flush_cnt_q == 3'd0) begin
                        state_d = RUN;
                    end else begin
                        flush_cnt_d = flush_cnt_q - 3'd1;
                    end
                end
                if (redirect) begin
                    if (misaligned) begin
                        state_d    = HALT;
                        misalign_d = 1'b1;
                    end else begin
                        pc_d        = target;
                        state_d     = FLUSH;
                        flush_cnt_d = FLUSH_LOAD;
                    end
                end else if (accept) begin
                    pc_d          = pc_q + XLEN'(INSTR_BYTES);
                    fetch_valid_d = 1'b1;
                    fetch_pc_d    = pc_q;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    assign pc_o          = pc_q;
    assign imem_addr_o   = pc_q;
    assign fetch_valid_o = fetch_valid_q;
    assign fetch_pc_o    = fetch_pc_q;
    assign flush_o       = (state_q == FLUSH);
    assign misalign_o    = misalign_q;

`ifdef FETCH_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] redir_cnt_q, redir_cnt_d;

    // Misaligned redirects still count: they were taken, they just halted us.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        redir_cnt_d = redir_cnt_q;
        if (active && stall_i) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (active && redirect) begin
            redir_cnt_d = redir_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            redir_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            redir_cnt_q <= redir_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign redir_cnt_o = redir_cnt_q;
`else
    assign stall_cnt_o = '0;
    assign redir_cnt_o = '0;
`endif

endmodule : fetch_ctrl

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios then random traffic,
// compared every cycle against a cycle-level reference model of the fetch rules.
module tb_fetch_ctrl;

    localparam int          FLUSH_CYCLES = 2;
    localparam logic [31:0] RESET_PC     = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_i, jalr_i, jal_i, br_i, imem_ready_i;
    logic [31:0] jalr_tgt_i, jal_tgt_i, br_tgt_i;
    logic        imem_req_o, fetch_valid_o, flush_o, misalign_o;
    logic [31:0] imem_addr_o, pc_o, fetch_pc_o, stall_cnt_o, redir_cnt_o;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    bit          mBooted, mHalted, mFv, mMis;
    int          mFlushLeft;
    logic [31:0] mPc, mFpc, mScnt, mRcnt;

    fetch_ctrl #(
        .XLEN(32), .RESET_PC(RESET_PC), .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(32)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stall_i       (stall_i),
        .jalr_i        (jalr_i),
        .jal_i         (jal_i),
        .br_i          (br_i),
        .jalr_tgt_i    (jalr_tgt_i),
        .jal_tgt_i     (jal_tgt_i),
        .br_tgt_i      (br_tgt_i),
        .imem_ready_i  (imem_ready_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .pc_o          (pc_o),
        .fetch_valid_o (fetch_valid_o),
        .fetch_pc_o    (fetch_pc_o),
        .flush_o       (flush_o),
        .misalign_o    (misalign_o),
        .stall_cnt_o   (stall_cnt_o),
        .redir_cnt_o   (redir_cnt_o)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mBooted    = 1'b0;
        mHalted    = 1'b0;
        mFv        = 1'b0;
        mMis       = 1'b0;
        mFlushLeft = 0;
        mPc        = RESET_PC;
        mFpc       = '0;
        mScnt      = '0;
        mRcnt      = '0;
    endtask

    // One clock cycle: drive, check the current cycle against the model, advance the model.
    task automatic applyStimulus(input bit rst, input bit stall, input bit jalr, input bit jal,
                                 input bit br, input bit ready, input logic [31:0] jt,
                                 input logic [31:0] jlt, input logic [31:0] bt);
        bit          running, redir, eReq;
        logic [31:0] tgt;
        reset        = rst;
        stall_i      = stall;
        jalr_i       = jalr;
        jal_i        = jal;
        br_i         = br;
        imem_ready_i = ready;
        jalr_tgt_i   = jt;
        jal_tgt_i    = jlt;
        br_tgt_i     = bt;
        #1;
        running = mBooted && !mHalted;
        redir   = jalr || jal || br;
        eReq    = running && !stall && !redir;
        checkOutput("imem_req", {31'b0, imem_req_o}, {31'b0, eReq});
        checkOutput("imem_addr", imem_addr_o, mPc);
        checkOutput("pc", pc_o, mPc);
        checkOutput("fetch_valid", {31'b0, fetch_valid_o}, {31'b0, mFv});
        checkOutput("fetch_pc", fetch_pc_o, mFpc);
        checkOutput("flush", {31'b0, flush_o}, {31'b0, running && (mFlushLeft > 0)});
        checkOutput("misalign", {31'b0, misalign_o}, {31'b0, mMis});
`ifdef FETCH_PERF_CNT_EN
        checkOutput("stall_cnt", stall_cnt_o, mScnt);
        checkOutput("redir_cnt", redir_cnt_o, mRcnt);
`else
        checkOutput("stall_cnt", stall_cnt_o, 32'h0);
        checkOutput("redir_cnt", redir_cnt_o, 32'h0);
`endif
        if (rst) begin
            modelReset();
        end else if (!mBooted) begin
            mBooted = 1'b1;
            mFv     = 1'b0;
        end else if (mHalted) begin
            mFv = 1'b0;
        end else begin
            mFv = 1'b0;
            if (stall) mScnt = mScnt + 1;
            if (redir) begin
                mRcnt = mRcnt + 1;
                tgt = jalr ? (jt & 32'hFFFF_FFFE) : (jal ? jlt : bt);
                if ((tgt & 32'h3) != 0) begin
                    mHalted    = 1'b1;
                    mMis       = 1'b1;
                    mFlushLeft = 0;
                end else begin
                    mPc        = tgt;
                    mFlushLeft = FLUSH_CYCLES;
                end
            end else begin
                if (mFlushLeft > 0) mFlushLeft = mFlushLeft - 1;
                if (eReq && ready) begin
                    mFv  = 1'b1;
                    mFpc = mPc;
                    mPc  = mPc + 4;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit stall, input bit ready);
        for (int i = 0; i < n; i++) applyStimulus(0, stall, 0, 0, 0, ready, 0, 0, 0);
    endtask

    task automatic branchTo(input logic [31:0] tgt, input bit ready);
        applyStimulus(0, 0, 0, 0, 1, ready, 32'h0, 32'h0, tgt);
    endtask

    initial begin
        reset = 1'b1; stall_i = 0; jalr_i = 0; jal_i = 0; br_i = 0; imem_ready_i = 1;
        jalr_tgt_i = 0; jal_tgt_i = 0; br_tgt_i = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        modelReset();

        // Boot then sequential fetch from RESET_PC
        idle(4, 0, 1);

        // Hold with imem not ready at 0x10
        idle(1, 0, 1);
        idle(3, 0, 0);
        idle(3, 0, 1);

        // All three redirect sources at once: jalr wins with bit 0 cleared
        applyStimulus(0, 0, 1, 1, 1, 1, 32'h101, 32'h200, 32'h300);
        idle(4, 0, 1);

        // Land on 0x20 without fetching through the flush, then stall 4 cycles
        branchTo(32'h20, 0);
        idle(2, 0, 0);
        idle(4, 1, 1);
        idle(3, 0, 1);

        // Stall and redirect together: redirect wins
        applyStimulus(0, 1, 0, 1, 0, 1, 32'h0, 32'h400, 32'h0);
        idle(3, 0, 1);

        // Misaligned branch halts; inputs ignored until reset
        branchTo(32'h42, 1);
        applyStimulus(0, 0, 1, 0, 0, 1, 32'h500, 32'h0, 32'h0);
        idle(2, 1, 1);
        applyStimulus(1, 0, 0, 0, 0, 1, 0, 0, 0);
        idle(3, 0, 1);

        // Re-target on the second flush cycle, then reset mid-flush
        branchTo(32'h80, 0);
        idle(1, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0, 32'h0, 32'hC0, 32'h0);
        idle(1, 0, 1);
        applyStimulus(1, 0, 0, 0, 0, 1, 0, 0, 0);
        idle(3, 0, 1);

        // PC wraps modulo 2^32; jalr with odd target stays aligned
        branchTo(32'hFFFF_FFF8, 1);
        idle(4, 0, 1);
        applyStimulus(0, 0, 1, 0, 0, 1, 32'h0000_1235, 32'h0, 32'h0);
        idle(2, 0, 1);

        // Randomised traffic with occasional resets to leave HALT
        for (int i = 0; i < 500; i++) begin
            bit          rst, stall, jalr, jal, br, ready;
            logic [31:0] jt, jlt, bt;
            rst   = ($urandom_range(0, 59) == 0);
            stall = ($urandom_range(0, 4) == 0);
            jalr  = ($urandom_range(0, 24) == 0);
            jal   = ($urandom_range(0, 19) == 0);
            br    = ($urandom_range(0, 14) == 0);
            ready = ($urandom_range(0, 3) != 0);
            jt    = $urandom & 32'hFFFF_FFFD;
            jlt   = $urandom & 32'hFFFF_FFFC;
            bt    = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 29) == 0) jt  = jt | 32'h2;
            if ($urandom_range(0, 29) == 0) jlt = jlt | 32'h1;
            if ($urandom_range(0, 29) == 0) bt  = bt | 32'h2;
            applyStimulus(rst, stall, jalr, jal, br, ready, jt, jlt, bt);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule : tb_fetch_ctrl
